symbol_serializer_pp: RTL and testbench

- Parametrised, double-buffered successor to the QPSK symbol serializer.
- Accepts BLOCK_W-bit cipher blocks from the AES encryptor and emits 1-, 2- or 4-bit symbols to the modulator (BPSK/QPSK/16-QAM).
- Uses a ping-pong holding register, so the encryptor can deliver block N+1 while block N is still being transmitted.
- Consecutive blocks stream with no idle cycle.

---
 rtl/zmodem_pkg.sv | 27 ++
 rtl/symbol_serializer_pp_sym_shift_unit.sv | 77 +++++++
 rtl/symbol_serializer_pp.sv | 122 ++++++++++++
 tb/tb_symbol_serializer_pp.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zmodem_pkg.sv
// Shared types and helpers for the modem symbol path.
// Symbol modes, per-mode symbol width and default block size.
package zmodem_pkg;

  localparam int BLOCK_W_DEF = 128;

  localparam logic [1:0] SYM_MODE_BPSK  = 2'd0;
  localparam logic [1:0] SYM_MODE_QPSK  = 2'd1;
  localparam logic [1:0] SYM_MODE_QAM16 = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_TX
  } ser_state_e;

  // Reserved mode 3 falls back to two bits per symbol.
  function automatic logic [2:0] sym_width(input logic [1:0] mode);
    logic [2:0] w;
    unique case (1'b1)
      (mode == SYM_MODE_BPSK):  w = 3'd1;
      (mode == SYM_MODE_QAM16): w = 3'd4;
      default:                  w = 3'd2;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/symbol_serializer_pp_sym_shift_unit.sv
// Active block shift register for the symbol serializer.
// Holds the block in flight, its symbol width and remaining count.
import zmodem_pkg::*;

module sym_shift_unit #(
  parameter int BLOCK_W   = BLOCK_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic [2:0]         load_w,
  input  logic               advance,
  output logic [3:0]         sym_data,
  output logic               last
);

  localparam int CW = $clog2(BLOCK_W) + 1;

  logic [BLOCK_W-1:0] sh_q, sh_d;
  logic [2:0]         w_q, w_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [3:0]         edge4;

  // Load a fresh block or shift out the symbol just taken.
  always_comb begin
    sh_d  = sh_q;
    w_d   = w_q;
    rem_d = rem_q;
    if (load) begin
      sh_d = load_data;
      w_d  = load_w;
      unique case (1'b1)
        (load_w == 3'd1): rem_d = CW'(BLOCK_W - 1);
        (load_w == 3'd4): rem_d = CW'(BLOCK_W / 4 - 1);
        default:          rem_d = CW'(BLOCK_W / 2 - 1);
      endcase
    end else if (advance) begin
      if (MSB_FIRST) sh_d = sh_q << w_q;
      else           sh_d = sh_q >> w_q;
      rem_d = rem_q - CW'(1);
    end
  end

  // Current symbol sits at the leading edge of the shift register.
  always_comb begin
    if (MSB_FIRST) edge4 = sh_q[BLOCK_W-1 -: 4];
    else           edge4 = sh_q[3:0];
    unique case (1'b1)
      (w_q == 3'd1):
        sym_data = MSB_FIRST ? {3'b0, edge4[3]}
                             : {3'b0, edge4[0]};
      (w_q == 3'd2):
        sym_data = MSB_FIRST ? {2'b0, edge4[3:2]}
                             : {2'b0, edge4[1:0]};
      default:
        sym_data = edge4;
    endcase
  end

  assign last = (rem_q == '0);

  // Active block state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      w_q   <= 3'd0;
      rem_q <= '0;
    end else begin
      sh_q  <= sh_d;
      w_q   <= w_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/symbol_serializer_pp.sv
// Ping-pong block-to-symbol serializer feeding the modulator.
// Hold buffer lets the next block queue behind the one in flight.
import zmodem_pkg::*;

module symbol_serializer_pp #(
  parameter int BLOCK_W   = BLOCK_W_DEF,
  parameter int MAX_SYM_W = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLOCK_W-1:0]   blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [1:0]           sym_mode,
  output logic [MAX_SYM_W-1:0] sym_data,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 sym_last,
  output logic                 underrun,
  output logic [15:0]          blk_count
);

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] hold_q, hold_d;
  logic [2:0]         hold_w_q, hold_w_d;
  logic               hold_full_q, hold_full_d;
  logic [15:0]        blk_count_q, blk_count_d;
  logic               underrun_q, underrun_d;

  logic               tx;
  logic               fire_sym;
  logic               fire_last;
  logic               accept;
  logic               load_direct;
  logic               to_hold;
  logic               move_hold;
  logic               u_load;
  logic               u_adv;
  logic [BLOCK_W-1:0] u_data;
  logic [2:0]         u_w;
  logic [3:0]         u_sym;
  logic               u_last;

  assign tx          = (state_q == ST_TX);
  assign fire_sym    = tx & sym_ready;
  assign fire_last   = fire_sym & u_last;
  assign accept      = blk_valid & ~hold_full_q;
  assign load_direct = accept & (~tx | fire_last);
  assign to_hold     = accept & ~load_direct;
  assign move_hold   = fire_last & hold_full_q;
  assign u_load      = load_direct | move_hold;
  assign u_adv       = fire_sym & ~u_last;
  assign u_data      = move_hold ? hold_q : blk_data;
  assign u_w         = move_hold ? hold_w_q
                                 : sym_width(sym_mode);

  sym_shift_unit #(
    .BLOCK_W   (BLOCK_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (u_load),
    .load_data (u_data),
    .load_w    (u_w),
    .advance   (u_adv),
    .sym_data  (u_sym),
    .last      (u_last)
  );

  // Hold buffer, FSM, block counter and underrun pulse.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_w_d    = hold_w_q;
    hold_full_d = hold_full_q;
    blk_count_d = blk_count_q;
    underrun_d  = 1'b0;
    if (fire_last) blk_count_d = blk_count_q + 16'd1;
    if (to_hold) begin
      hold_d      = blk_data;
      hold_w_d    = sym_width(sym_mode);
      hold_full_d = 1'b1;
    end else if (move_hold) begin
      hold_full_d = 1'b0;
    end
    if (u_load) begin
      state_d = ST_TX;
    end else if (fire_last) begin
      state_d    = ST_IDLE;
      underrun_d = 1'b1;
    end
  end

  // Control and hold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_w_q    <= 3'd0;
      hold_full_q <= 1'b0;
      blk_count_q <= 16'd0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_w_q    <= hold_w_d;
      hold_full_q <= hold_full_d;
      blk_count_q <= blk_count_d;
      underrun_q  <= underrun_d;
    end
  end

  assign blk_ready = ~hold_full_q;
  assign sym_valid = tx;
  assign sym_data  = tx ? MAX_SYM_W'(u_sym) : '0;
  assign sym_last  = tx & u_last;
  assign underrun  = underrun_q;
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_symbol_serializer_pp.sv
// Directed bench for symbol_serializer_pp (BLOCK_W=128, MSB first).
// Vector table plus multi-block, backpressure and reset sequences.
module tb_symbol_serializer_pp;
  import zmodem_pkg::*;

  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] blk_data = '0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [1:0]    sym_mode = 2'd1;
  logic [3:0]    sym_data;
  logic          sym_valid;
  logic          sym_ready = 1'b1;
  logic          sym_last;
  logic          underrun;
  logic [15:0]   blk_count;

  symbol_serializer_pp #(
    .BLOCK_W   (BW),
    .MAX_SYM_W (4),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .sym_mode  (sym_mode),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last),
    .underrun  (underrun),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] blk;
    int           n;
    logic [3:0]   s0;
    logic [3:0]   s1;
    logic [3:0]   sl;
  } vec_t;

  vec_t vt[5];

  logic [3:0] q_sym[$];
  bit         q_last[$];
  int         q_cyc[$];
  logic [3:0] e_sym[$];
  bit         e_last[$];
  int         und_cnt = 0;
  int         cyc = 0;
  bit         rnd_en = 1'b0;

  bit         st_pend = 1'b0;
  logic [3:0] st_data;
  logic       st_last;

  // Observe handshakes, underrun pulses and stall stability.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      st_pend = 1'b0;
    end else begin
      if (st_pend)
        chk("stall_hold",
            128'({sym_valid, sym_last, sym_data}),
            128'({1'b1, st_last, st_data}));
      st_pend = sym_valid && !sym_ready;
      st_data = sym_data;
      st_last = sym_last;
      if (sym_valid && sym_ready) begin
        q_sym.push_back(sym_data);
        q_last.push_back(sym_last);
        q_cyc.push_back(cyc);
      end
      if (underrun) und_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      if (rnd_en) sym_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [3:0] ref_sym(input logic [127:0] b,
                                         input logic [1:0] m,
                                         input int k);
    int w;
    logic [127:0] t;
    logic [3:0] mask;
    w = (m == 2'd0) ? 1 : (m == 2'd2) ? 4 : 2;
    mask = (w == 1) ? 4'h1 : (w == 2) ? 4'h3 : 4'hF;
    t = b >> (BW - (k + 1) * w);
    return t[3:0] & mask;
  endfunction

  task automatic add_exp(input logic [127:0] b,
                         input logic [1:0] m);
    int n;
    n = (m == 2'd0) ? BW : (m == 2'd2) ? BW / 4 : BW / 2;
    for (int k = 0; k < n; k++) begin
      e_sym.push_back(ref_sym(b, m, k));
      e_last.push_back(k == n - 1);
    end
  endtask

  task automatic clear_all();
    q_sym.delete();
    q_last.delete();
    q_cyc.delete();
    e_sym.delete();
    e_last.delete();
    und_cnt = 0;
  endtask

  task automatic cmp_stream(input string nm);
    int bad0;
    int n;
    chk({nm, "_len"}, 128'(q_sym.size()), 128'(e_sym.size()));
    n = (q_sym.size() < e_sym.size()) ? q_sym.size()
                                      : e_sym.size();
    for (int i = 0; i < n; i++) begin
      bad0 = checks - passes;
      chk($sformatf("%s_sym[%0d]", nm, i),
          128'(q_sym[i]), 128'(e_sym[i]));
      chk($sformatf("%s_last[%0d]", nm, i),
          128'(q_last[i]), 128'(e_last[i]));
      if (checks - passes != bad0) break;
    end
  endtask

  task automatic send(input logic [127:0] b,
                      input logic [1:0] m,
                      output int waited);
    waited = 0;
    blk_data = b;
    sym_mode = m;
    blk_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (blk_ready) break;
      waited++;
      if (waited > 2000) begin
        chk("send_timeout", 128'(1), 128'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    blk_data = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!sym_valid && blk_ready) break;
      n++;
      if (n > 5000) begin
        chk("drain_timeout", 128'(1), 128'(0));
        break;
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  int         bc_exp = 0;
  int         wt;
  int         nl;

  initial begin
    vt[0] = '{2'd1, 128'h0123456789ABCDEF0123456789ABCDEF,
              64, 4'h0, 4'h0, 4'h3};
    vt[1] = '{2'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
              128, 4'h1, 4'h0, 4'h1};
    vt[2] = '{2'd2, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
              32, 4'h8, 4'h0, 4'h1};
    vt[3] = '{2'd3, 128'hC000_0000_0000_0000_0000_0000_0000_0002,
              64, 4'h3, 4'h0, 4'h2};
    vt[4] = '{2'd2, 128'hFEDCBA98765432100123456789ABCDEF,
              32, 4'hF, 4'hE, 4'hF};

    #3;
    chk("rst_blk_ready", 128'(blk_ready), 128'(1));
    chk("rst_outputs",
        128'({sym_valid, sym_data, sym_last, underrun}), 128'(0));
    chk("rst_blk_count", 128'(blk_count), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      clear_all();
      add_exp(vt[i].blk, vt[i].mode);
      send(vt[i].blk, vt[i].mode, wt);
      drain();
      bc_exp++;
      chk($sformatf("v%0d_count", i),
          128'(q_sym.size()), 128'(vt[i].n));
      if (q_sym.size() == vt[i].n) begin
        chk($sformatf("v%0d_s0", i), 128'(q_sym[0]), 128'(vt[i].s0));
        chk($sformatf("v%0d_s1", i), 128'(q_sym[1]), 128'(vt[i].s1));
        chk($sformatf("v%0d_slast", i),
            128'(q_sym[vt[i].n - 1]), 128'(vt[i].sl));
        chk($sformatf("v%0d_lastflag", i),
            128'(q_last[vt[i].n - 1]), 128'(1));
      end
      nl = 0;
      foreach (q_last[j]) if (q_last[j]) nl++;
      chk($sformatf("v%0d_nlast", i), 128'(nl), 128'(1));
      chk($sformatf("v%0d_underrun", i), 128'(und_cnt), 128'(1));
      chk($sformatf("v%0d_blk_count", i),
          128'(blk_count), 128'(bc_exp));
      cmp_stream($sformatf("v%0d", i));
    end

    // Back-to-back: second block waits in hold, no bubble.
    clear_all();
    add_exp(vt[0].blk, vt[0].mode);
    add_exp(vt[4].blk, vt[4].mode);
    send(vt[0].blk, vt[0].mode, wt);
    send(vt[4].blk, vt[4].mode, wt);
    chk("b2b_hold_accept_wait", 128'(wt), 128'(0));
    drain();
    bc_exp += 2;
    cmp_stream("b2b");
    chk("b2b_underrun", 128'(und_cnt), 128'(1));
    chk("b2b_blk_count", 128'(blk_count), 128'(bc_exp));
    if (q_cyc.size() > 64)
      chk("b2b_gap", 128'(q_cyc[64] - q_cyc[63]), 128'(1));
    else
      chk("b2b_short", 128'(q_cyc.size()), 128'(96));

    // Random backpressure, third block stalls on full buffers.
    clear_all();
    add_exp(vt[0].blk, 2'd1);
    add_exp(vt[1].blk, 2'd2);
    add_exp(vt[4].blk, 2'd0);
    rnd_en = 1'b1;
    send(vt[0].blk, 2'd1, wt);
    send(vt[1].blk, 2'd2, wt);
    send(vt[4].blk, 2'd0, wt);
    chk("bp_third_blocked", 128'(wt > 0), 128'(1));
    drain();
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    sym_ready = 1'b1;
    bc_exp += 3;
    cmp_stream("bp");
    chk("bp_underrun", 128'(und_cnt), 128'(1));
    chk("bp_blk_count", 128'(blk_count), 128'(bc_exp));

    // Mode change while active and held blocks are pending.
    clear_all();
    add_exp(vt[0].blk, 2'd1);
    add_exp(vt[4].blk, 2'd1);
    send(vt[0].blk, 2'd1, wt);
    send(vt[4].blk, 2'd1, wt);
    repeat (10) @(posedge clk);
    #1;
    sym_mode = 2'd2;
    drain();
    chk("mode_first_len", 128'(q_sym.size()), 128'(128));
    add_exp(vt[1].blk, 2'd2);
    send(vt[1].blk, 2'd2, wt);
    drain();
    bc_exp += 3;
    cmp_stream("mode");
    chk("mode_underrun", 128'(und_cnt), 128'(2));
    chk("mode_blk_count", 128'(blk_count), 128'(bc_exp));

    // Reset mid-block with hold full.
    clear_all();
    send(vt[0].blk, 2'd1, wt);
    send(vt[4].blk, 2'd2, wt);
    wt = 0;
    forever begin
      @(negedge clk);
      if (q_sym.size() >= 20) break;
      wt++;
      if (wt > 500) begin
        chk("rst_wait_timeout", 128'(1), 128'(0));
        break;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs",
        128'({sym_valid, sym_data, sym_last, underrun}), 128'(0));
    chk("mid_rst_blk_ready", 128'(blk_ready), 128'(1));
    chk("mid_rst_blk_count", 128'(blk_count), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bc_exp = 0;
    clear_all();
    repeat (20) @(negedge clk);
    chk("post_rst_silent", 128'(q_sym.size()), 128'(0));
    chk("post_rst_valid", 128'(sym_valid), 128'(0));
    @(posedge clk);
    #1;
    add_exp(vt[2].blk, vt[2].mode);
    send(vt[2].blk, vt[2].mode, wt);
    drain();
    bc_exp++;
    cmp_stream("post_rst");
    chk("post_rst_blk_count", 128'(blk_count), 128'(bc_exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
